// File: rtl/tape_pkg.sv
// rtl/tape_pkg.sv - shared state encoding and leader constants for the tape player
// Optional feature macro: TAPE_LEADER_EN adds the LEADER state.
package tape_pkg;

  localparam logic [7:0] SYNC_BYTE    = 8'hE6;
  localparam int         LEADER_BYTES = 256;

`ifdef TAPE_LEADER_EN
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE,
    LEADER
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } state_t;
`endif

endpackage

// File: rtl/tape_bitcell.sv
// rtl/tape_bitcell.sv - half-cell timer and MSB-first biphase byte serializer
module tape_bitcell #(
  parameter int HALF_CYCLES = 5000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] byte_in,
  input  logic       freeze,
  output logic       tapein,
  output logic       byte_done
);

  localparam int            CW       = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic [3:0]    half;
  logic [7:0]    shreg;
  logic          busy;
  logic          level;
  logic          cell_end;

  // A half-cell ends on its last clock; the byte ends with the 16th half-cell.
  // While frozen the counter parks on that last clock, so byte_done stays high.
  assign cell_end  = busy && (cnt == CNT_LAST);
  assign byte_done = cell_end && (half == 4'd15);
  assign tapein    = level;

  // Shift out each bit as (~bit, bit); after the final half-cell the level is held.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      half  <= '0;
      shreg <= '0;
      busy  <= 1'b0;
      level <= 1'b0;
    end else if (load) begin
      cnt   <= '0;
      half  <= '0;
      shreg <= byte_in;
      busy  <= 1'b1;
      level <= ~byte_in[7];
    end else if (clear) begin
      cnt   <= '0;
      half  <= '0;
      shreg <= '0;
      busy  <= 1'b0;
      level <= 1'b0;
    end else if (busy && !freeze) begin
      if (!cell_end) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        if (half == 4'd15) begin
          busy <= 1'b0;
        end else begin
          half <= half + 4'd1;
          if (!half[0]) begin
            level <= shreg[7];
          end else begin
            shreg <= {shreg[6:0], 1'b0};
            level <= ~shreg[6];
          end
        end
      end
    end
  end

endmodule

// File: rtl/tape_player.sv
// rtl/tape_player.sv - plays a buffered tape image as a biphase cassette signal
// Optional feature macro: TAPE_LEADER_EN prepends 256 x 0x00 leader bytes and a 0xE6 sync byte.
module tape_player
  import tape_pkg::*;
#(
  parameter int HALF_CYCLES = 5000,
  parameter int AW          = 24
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] tape_size,
  output logic [AW-1:0] buf_addr,
  output logic          buf_rd,
  input  logic [7:0]    buf_data,
  input  logic          buf_ack,
  output logic          tapein,
  output logic          playing,
  output logic          done
);

  state_t        state, state_n;
  logic [AW-1:0] size_q, size_n;
  logic [AW-1:0] addr_n;
  logic [7:0]    hold_q, hold_n;
  logic          hold_valid, hold_valid_n;
  logic          rd_q, rd_n;
  logic          done_q, done_n;
  logic          ack;

  logic          cell_clear;
  logic          cell_load;
  logic          cell_freeze;
  logic [7:0]    cell_byte;
  logic          cell_level;
  logic          byte_done;

`ifdef TAPE_LEADER_EN
  logic [8:0]    lead_cnt, lead_cnt_n;
`endif

  // An ack only counts while our own request is still outstanding.
  assign ack     = buf_ack && rd_q;
  assign buf_rd  = rd_q;
  assign done    = done_q;
  assign playing = (state != IDLE) && (state != DONE);
  assign tapein  = playing && cell_level;

  tape_bitcell #(
    .HALF_CYCLES(HALF_CYCLES)
  ) u_bitcell (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .clear    (cell_clear),
    .load     (cell_load),
    .byte_in  (cell_byte),
    .freeze   (cell_freeze),
    .tapein   (cell_level),
    .byte_done(byte_done)
  );

  // State, address, holding byte and request flag registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      size_q     <= '0;
      buf_addr   <= '0;
      hold_q     <= '0;
      hold_valid <= 1'b0;
      rd_q       <= 1'b0;
      done_q     <= 1'b0;
`ifdef TAPE_LEADER_EN
      lead_cnt   <= '0;
`endif
    end else begin
      state      <= state_n;
      size_q     <= size_n;
      buf_addr   <= addr_n;
      hold_q     <= hold_n;
      hold_valid <= hold_valid_n;
      rd_q       <= rd_n;
      done_q     <= done_n;
`ifdef TAPE_LEADER_EN
      lead_cnt   <= lead_cnt_n;
`endif
    end
  end

  // Next-state logic: stop beats start, start beats everything else; in SHIFT the
  // ack/holding register decides whether the serializer reloads, stalls or finishes.
  always_comb begin
    state_n      = state;
    size_n       = size_q;
    addr_n       = buf_addr;
    hold_n       = hold_q;
    hold_valid_n = hold_valid;
    rd_n         = rd_q;
    done_n       = done_q;
    cell_clear   = 1'b0;
    cell_load    = 1'b0;
    cell_freeze  = 1'b0;
    cell_byte    = hold_q;
`ifdef TAPE_LEADER_EN
    lead_cnt_n   = lead_cnt;
`endif

    if (stop) begin
      state_n      = IDLE;
      rd_n         = 1'b0;
      hold_valid_n = 1'b0;
      cell_clear   = 1'b1;
    end else if (start) begin
      addr_n       = '0;
      rd_n         = 1'b0;
      hold_valid_n = 1'b0;
      cell_clear   = 1'b1;
      if (tape_size == '0) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end else begin
        size_n  = tape_size;
        done_n  = 1'b0;
`ifdef TAPE_LEADER_EN
        state_n    = LEADER;
        lead_cnt_n = '0;
        cell_load  = 1'b1;
        cell_byte  = 8'h00;
`else
        state_n = FETCH;
        rd_n    = 1'b1;
`endif
      end
    end else begin
      case (state)
`ifdef TAPE_LEADER_EN
        LEADER: begin
          if (byte_done) begin
            if (lead_cnt == 9'(LEADER_BYTES)) begin
              state_n = FETCH;
              rd_n    = 1'b1;
            end else begin
              cell_load  = 1'b1;
              cell_byte  = (lead_cnt == 9'(LEADER_BYTES - 1)) ? SYNC_BYTE : 8'h00;
              lead_cnt_n = lead_cnt + 9'd1;
            end
          end
        end
`endif
        FETCH: begin
          if (ack) begin
            cell_load = 1'b1;
            cell_byte = buf_data;
            addr_n    = buf_addr + 1'b1;
            rd_n      = 1'b0;
            state_n   = SHIFT;
          end
        end
        SHIFT: begin
          if (ack) begin
            addr_n = buf_addr + 1'b1;
            rd_n   = 1'b0;
            if (byte_done && !hold_valid) begin
              cell_load = 1'b1;
              cell_byte = buf_data;
            end else begin
              hold_n       = buf_data;
              hold_valid_n = 1'b1;
            end
          end else if (byte_done) begin
            if (hold_valid) begin
              cell_load    = 1'b1;
              cell_byte    = hold_q;
              hold_valid_n = 1'b0;
            end else if (rd_q || (buf_addr < size_q)) begin
              cell_freeze = 1'b1;
            end else begin
              state_n = DONE;
              done_n  = 1'b1;
            end
          end
          if (!rd_q && !hold_valid && (buf_addr < size_q)) begin
            rd_n = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
